dcache_dm: RTL and testbench
============================

// Module: dcache_dm
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and memory.
//  Serves 32-bit word reads/writes on hit in the request cycle.
//  On miss, stalls the pipeline, writes back a dirty victim line, then fills the line from memory.
//  Memory side moves whole WIDTH-bit lines with memread/memwrite strobes.
// PARAMETERS
//  WIDTH    128  line width in bits; equals the memory word width
//  LINES    8    number of cache lines (power of 2)
//  ADDR     32   address width
//  DATA_W   32   CPU word width
//  MEM_LAT  4    cycles each memory strobe is held (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  addr       in   ADDR    CPU address
//  wdata      in   DATA_W  CPU store data
//  memread    in   1       CPU load request
//  memwrite   in   1       CPU store request
//  rdata      out  DATA_W  load data, valid when memread && !stall
//  stall      out  1       CPU must hold addr/wdata/memread/memwrite while high
//  mem_addr   out  ADDR    line address to memory, offset bits zero
//  mem_wdata  out  WIDTH   victim line
//  mem_rdata  in   WIDTH   fill line, combinational from memory
//  mem_read   out  1       memory read strobe
//  mem_write  out  1       memory write strobe
// BEHAVIOUR
//  Address split uses memory decoding:
//    OB = $clog2(WIDTH) offset bits, word select = addr[OB-1:$clog2(DATA_W)]
//    index = addr[OB+$clog2(LINES)-1:OB], tag = remaining upper bits
//  Reset (async): state=IDLE, all valid/dirty=0, counter=0, all outputs 0.
//    Line data is not cleared.
//    Reset mid-WB/FILL aborts immediately: strobes drop, no line is installed.
//  hit = req && valid[index] && tag_mem[index]==tag, where req = memread|memwrite.
//  stall = (state!=IDLE) | (req & !hit); purely combinational.
//  memread && memwrite together: treat as a store; rdata is don't-care.
//  States:
//   IDLE:
//    - load hit: rdata = selected word, same cycle.
//    - store hit: word written at posedge, dirty[index]=1.
//    - miss with dirty victim -> WB; miss with clean victim -> FILL.
//   WB:
//    - mem_write=1, mem_addr={victim_tag,index,0}, mem_wdata=victim line.
//    - held MEM_LAT cycles, then -> FILL.
//   FILL:
//    - mem_read=1, mem_addr={tag,index,0}, held MEM_LAT cycles.
//    - on last cycle: line=mem_rdata, tag stored, valid=1, dirty=0 -> IDLE.
//   Next cycle in IDLE the held request hits and completes there.
//  Counter counts 0..MEM_LAT-1 and clears on every state change. It never wraps past MEM_LAT-1.
//  Miss penalty:
//    clean = MEM_LAT+1 stall cycles
//    dirty = 2*MEM_LAT+1 stall cycles
//  mem_read and mem_write are never high together and are 0 in IDLE.
//  Index/tag of the pending miss are sampled from addr (CPU holds it), not latched.
// STRUCTURE
//  Shared in defines.v:
//    - state encodings DC_IDLE/DC_WB/DC_FILL (2 bits)
//    - address-field width macros
//  Sub-module dcache_meta: valid/dirty/tag arrays.
//    - async-reset valid/dirty, write ports for install and dirty-set
//    - combinational lookup giving hit and victim tag
//  FSM, counter and data array stay in dcache_dm.
// TESTING
//  1 After reset, load addr 0x000 -> stall=1 for MEM_LAT+1=5 cycles, mem_read=1 for 4, then rdata=mem word.
//  2 Store 0xDEADBEEF to 0x020 on resident line -> stall=0, no memory strobes, dirty set, reload returns 0xDEADBEEF.
//  3 Dirty line idx0, load addr with same index/new tag (0x400) -> mem_write 4 cycles with old line, then mem_read 4 cycles, 9 stall cycles.
//  4 Assert reset in 2nd cycle of WB -> strobes 0 same cycle, next load to 0x400 misses clean: no writeback.
//  5 memread=memwrite=1 on hit -> behaves as store only, dirty=1, no stall.
//  6 Fill all LINES lines, reread each -> all hits, zero stalls, correct words.

Source files
------------

// File: rtl/dcache_dm_pkg.sv
// Shared definitions for the direct-mapped data cache.
// Holds the controller state encoding and the default geometry used by
// dcache_dm and its metadata sub-module dcache_meta.
package dcache_dm_pkg;

   // Default geometry
   localparam int DC_WIDTH   = 128;  // line width in bits (one memory word)
   localparam int DC_LINES   = 8;    // number of cache lines
   localparam int DC_ADDR    = 32;   // address width
   localparam int DC_DATA_W  = 32;   // CPU word width
   localparam int DC_MEM_LAT = 4;    // cycles each memory strobe is held

   // Controller states
   typedef enum logic [1:0] {
      DC_IDLE = 2'd0,
      DC_WB   = 2'd1,
      DC_FILL = 2'd2
   } dc_state_e;

endpackage

// File: rtl/dcache_dm_meta.sv
// Metadata store for the direct-mapped data cache.
// Holds the valid, dirty and tag arrays. Valid and dirty bits are cleared by
// reset; tags are not, because a tag is only ever looked at together with
// its valid bit.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   lookup_index    line index being looked up
//   lookup_tag      tag being compared against the stored tag
//   lookup_hit      stored line is valid and its tag matches
//   victim_tag      tag currently stored at lookup_index
//   victim_dirty    line at lookup_index is valid and dirty
//   install_en      install a freshly filled line (valid=1, dirty=0)
//   install_index   line index to install
//   install_tag     tag to install
//   dirty_set_en    mark a line dirty after a store hit
//   dirty_index     line index to mark dirty
module dcache_meta
   import dcache_dm_pkg::*;
#(
   parameter int LINES = DC_LINES,
   parameter int IDX_W = $clog2(DC_LINES),
   parameter int TAG_W = 22
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] lookup_index,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             lookup_hit,
   output logic [TAG_W-1:0] victim_tag,
   output logic             victim_dirty,
   input  logic             install_en,
   input  logic [IDX_W-1:0] install_index,
   input  logic [TAG_W-1:0] install_tag,
   input  logic             dirty_set_en,
   input  logic [IDX_W-1:0] dirty_index
);

   logic [LINES-1:0] valid_q, valid_d;
   logic [LINES-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0] tag_q [LINES];

   assign lookup_hit   = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
   assign victim_tag   = tag_q[lookup_index];
   assign victim_dirty = valid_q[lookup_index] && dirty_q[lookup_index];

   // Install wins over dirty-set on the same line; the controller never
   // requests both in one cycle, but a freshly filled line must come up clean.
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (dirty_set_en) begin
         dirty_d[dirty_index] = 1'b1;
      end
      if (install_en) begin
         valid_d[install_index] = 1'b1;
         dirty_d[install_index] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tags are not reset.
   always_ff @(posedge clk) begin
      if (install_en) begin
         tag_q[install_index] <= install_tag;
      end
   end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache between the pipeline
// MEM stage and memory. Loads and stores that hit complete in the request
// cycle. A miss stalls the CPU, writes back a dirty victim line, then fills
// the line from memory; the held request then hits in IDLE.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   addr, wdata         CPU address and store data (held while stall is high)
//   memread, memwrite   CPU load / store requests (both high = store)
//   rdata               load data, valid when memread && !stall
//   stall               CPU must hold its request while high
//   mem_addr            line address to memory, offset bits zero
//   mem_wdata           victim line during writeback
//   mem_rdata           fill line, combinational from memory
//   mem_read, mem_write memory strobes, each held MEM_LAT cycles
module dcache_dm
   import dcache_dm_pkg::*;
#(
   parameter int WIDTH   = DC_WIDTH,
   parameter int LINES   = DC_LINES,
   parameter int ADDR    = DC_ADDR,
   parameter int DATA_W  = DC_DATA_W,
   parameter int MEM_LAT = DC_MEM_LAT
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR-1:0]   addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              memread,
   input  logic              memwrite,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic [ADDR-1:0]   mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic              mem_read,
   output logic              mem_write
);

   // Address decoding: OB offset bits, word select just above the CPU word
   // bits, index above the offset, tag in the remaining upper bits.
   localparam int OB    = $clog2(WIDTH);
   localparam int WB_LO = $clog2(DATA_W);
   localparam int SEL_W = OB - WB_LO;
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR - OB - IDX_W;
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_index;
   logic [SEL_W-1:0] word_sel;
   logic             unused_addr_bits;

   assign req_tag          = addr[ADDR-1 -: TAG_W];
   assign req_index        = addr[OB +: IDX_W];
   assign word_sel         = addr[WB_LO +: SEL_W];
   assign unused_addr_bits = ^addr[WB_LO-1:0];

   dc_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q [LINES];

   logic             req;
   logic             meta_hit;
   logic             hit;
   logic [TAG_W-1:0] victim_tag;
   logic             victim_dirty;
   logic             install_en;
   logic             dirty_set_en;
   logic             line_wr_en;
   logic [WIDTH-1:0] line_wr_data;
   logic [WIDTH-1:0] cur_line;

   assign req      = memread | memwrite;
   assign hit      = req & meta_hit;
   assign cur_line = data_q[req_index];
   assign stall    = (state_q != DC_IDLE) | (req & ~hit);
   assign rdata    = (hit && memread && !memwrite) ? cur_line[word_sel*DATA_W +: DATA_W]
                                                   : '0;

   // The pending miss uses the held CPU address, so install and dirty-set
   // both target req_index.
   dcache_meta #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_meta (
      .clk           (clk),
      .reset         (reset),
      .lookup_index  (req_index),
      .lookup_tag    (req_tag),
      .lookup_hit    (meta_hit),
      .victim_tag    (victim_tag),
      .victim_dirty  (victim_dirty),
      .install_en    (install_en),
      .install_index (req_index),
      .install_tag   (req_tag),
      .dirty_set_en  (dirty_set_en),
      .dirty_index   (req_index)
   );

   // Controller: next state, counter, memory strobes and array write enables.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      install_en   = 1'b0;
      dirty_set_en = 1'b0;
      line_wr_en   = 1'b0;
      line_wr_data = cur_line;
      unique case (state_q)
         DC_IDLE: begin
            if (hit && memwrite) begin
               dirty_set_en = 1'b1;
               line_wr_en   = 1'b1;
               line_wr_data[word_sel*DATA_W +: DATA_W] = wdata;
            end else if (req && !hit) begin
               state_d = victim_dirty ? DC_WB : DC_FILL;
               cnt_d   = '0;
            end
         end
         DC_WB: begin
            mem_write = 1'b1;
            mem_addr  = {victim_tag, req_index, {OB{1'b0}}};
            mem_wdata = cur_line;
            if (cnt_q == CNT_LAST) begin
               state_d = DC_FILL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DC_FILL: begin
            mem_read = 1'b1;
            mem_addr = {req_tag, req_index, {OB{1'b0}}};
            if (cnt_q == CNT_LAST) begin
               install_en   = 1'b1;
               line_wr_en   = 1'b1;
               line_wr_data = mem_rdata;
               state_d      = DC_IDLE;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = DC_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= DC_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Line data is not reset. A reset during FILL forces state_q to IDLE
   // asynchronously, so line_wr_en is low and no partial line is installed.
   always_ff @(posedge clk) begin
      if (line_wr_en) begin
         data_q[req_index] <= line_wr_data;
      end
   end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed scenarios followed by random
// load/store traffic, all checked against a line-level behavioural model of
// a direct-mapped write-back cache and its backing memory.
module tb_dcache_dm;

   localparam int MEM_LAT = 4;
   localparam int MAX_WAIT = 50;

   logic         clk;
   logic         reset;
   logic [31:0]  addr;
   logic [31:0]  wdata;
   logic         memread;
   logic         memwrite;
   logic [31:0]  rdata;
   logic         stall;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_read;
   logic         mem_write;

   int nCompared = 0;
   int nMismatched = 0;

   dcache_dm #(
      .WIDTH   (128),
      .LINES   (8),
      .ADDR    (32),
      .DATA_W  (32),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .memread   (memread),
      .memwrite  (memwrite),
      .rdata     (rdata),
      .stall     (stall),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write)
   );

   // Clock: period 10, rising edges at 5, 15, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Initial memory contents: a fixed pattern derived from the line address.
   function automatic logic [127:0] memLine(input logic [31:0] lineAddr);
      return {lineAddr ^ 32'h1111_0000, lineAddr + 32'h3, ~lineAddr, lineAddr * 32'h9E37_79B9};
   endfunction

   // Environment memory seen by the DUT. Addresses used stay below 0x10000,
   // so addr[15:7] identifies a line. A write commits once the strobe has
   // been held for MEM_LAT cycles; an aborted writeback commits nothing.
   logic [127:0] envMem [512];
   bit           envWritten [512];
   int           wrHold;

   always_comb begin
      if (envWritten[mem_addr[15:7]]) mem_rdata = envMem[mem_addr[15:7]];
      else                            mem_rdata = memLine({16'h0, mem_addr[15:7], 7'h0});
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wrHold <= 0;
      end else if (mem_write) begin
         if (wrHold == MEM_LAT - 1) begin
            envMem[mem_addr[15:7]]     <= mem_wdata;
            envWritten[mem_addr[15:7]] <= 1'b1;
            wrHold <= 0;
         end else begin
            wrHold <= wrHold + 1;
         end
      end else begin
         wrHold <= 0;
      end
   end

   // Reference model: cache contents and the memory the model believes in.
   bit           mValid [8];
   bit           mDirty [8];
   logic [21:0]  mTag   [8];
   logic [127:0] mData  [8];
   logic [127:0] modelMem [512];
   bit           modelWritten [512];

   function automatic logic [127:0] modelRead(input logic [31:0] lineAddr);
      if (modelWritten[lineAddr[15:7]]) return modelMem[lineAddr[15:7]];
      return memLine({16'h0, lineAddr[15:7], 7'h0});
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 8; i++) begin
         mValid[i] = 1'b0;
         mDirty[i] = 1'b0;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One CPU request: predict with the model, drive, then count stall and
   // strobe cycles until the request completes and compare everything.
   task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd);
      logic [2:0]   idx;
      logic [21:0]  tg;
      int           ws;
      bit           expHit, expWb, overlap;
      int           expStall, stallCnt, wbCnt, fillCnt;
      logic [31:0]  expWbAddr, expFillAddr, expRdata, wbAddrObs, fillAddrObs;
      logic [127:0] expWbData, wbDataObs;

      idx = a[9:7];
      tg  = a[31:10];
      ws  = int'(a[6:5]);
      expHit   = mValid[idx] && (mTag[idx] == tg);
      expWb    = !expHit && mValid[idx] && mDirty[idx];
      expStall = expHit ? 0 : (expWb ? 2 * MEM_LAT + 1 : MEM_LAT + 1);
      expWbAddr   = {mTag[idx], idx, 7'h0};
      expWbData   = mData[idx];
      expFillAddr = {tg, idx, 7'h0};
      if (expWb) begin
         modelMem[expWbAddr[15:7]]     = expWbData;
         modelWritten[expWbAddr[15:7]] = 1'b1;
      end
      if (!expHit) begin
         mData[idx]  = modelRead(expFillAddr);
         mTag[idx]   = tg;
         mValid[idx] = 1'b1;
         mDirty[idx] = 1'b0;
      end
      expRdata = mData[idx][ws*32 +: 32];
      if (wr) begin
         mData[idx][ws*32 +: 32] = wd;
         mDirty[idx] = 1'b1;
      end

      @(posedge clk);
      #1;
      memread  = rd;
      memwrite = wr;
      addr     = a;
      wdata    = wd;
      stallCnt = 0;
      wbCnt    = 0;
      fillCnt  = 0;
      overlap  = 1'b0;
      wbAddrObs   = '0;
      wbDataObs   = '0;
      fillAddrObs = '0;
      @(negedge clk);
      while (stall && stallCnt < MAX_WAIT) begin
         stallCnt++;
         if (mem_read && mem_write) overlap = 1'b1;
         if (mem_write) begin
            if (wbCnt == 0) begin
               wbAddrObs = mem_addr;
               wbDataObs = mem_wdata;
            end
            wbCnt++;
         end
         if (mem_read) begin
            if (fillCnt == 0) fillAddrObs = mem_addr;
            fillCnt++;
         end
         @(negedge clk);
      end
      checkOutput("stall_cycles", 128'(stallCnt), 128'(expStall));
      checkOutput("wb_cycles", 128'(wbCnt), 128'(expWb ? MEM_LAT : 0));
      checkOutput("fill_cycles", 128'(fillCnt), 128'(expHit ? 0 : MEM_LAT));
      checkOutput("strobe_overlap", 128'(overlap), 128'(0));
      if (expWb) begin
         checkOutput("wb_addr", 128'(wbAddrObs), 128'(expWbAddr));
         checkOutput("wb_data", wbDataObs, expWbData);
      end
      if (!expHit) checkOutput("fill_addr", 128'(fillAddrObs), 128'(expFillAddr));
      if (rd && !wr) checkOutput("rdata", 128'(rdata), 128'(expRdata));
      checkOutput("idle_mem_read", 128'(mem_read), 128'(0));
      checkOutput("idle_mem_write", 128'(mem_write), 128'(0));
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
      memread  = 1'b0;
      memwrite = 1'b0;
   endtask

   // Start a dirty-victim load miss and assert reset in the second WB cycle.
   task automatic abortWriteback(input logic [31:0] a);
      bit expDirtyMiss;
      expDirtyMiss = mValid[a[9:7]] && mDirty[a[9:7]] && (mTag[a[9:7]] != a[31:10]);
      checkOutput("abort_setup_dirty", 128'(expDirtyMiss), 128'(1));
      @(posedge clk);
      #1;
      memread  = 1'b1;
      memwrite = 1'b0;
      addr     = a;
      @(negedge clk);
      checkOutput("abort_miss_stall", 128'(stall), 128'(1));
      @(negedge clk);
      checkOutput("abort_wb1_write", 128'(mem_write), 128'(1));
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("abort_mem_write", 128'(mem_write), 128'(0));
      checkOutput("abort_mem_read", 128'(mem_read), 128'(0));
      memread = 1'b0;
      @(negedge clk);
      checkOutput("abort_reset_stall", 128'(stall), 128'(0));
      reset = 1'b0;
      modelReset();
   endtask

   initial begin
      logic [31:0] a;
      int op;

      reset    = 1'b1;
      addr     = '0;
      wdata    = '0;
      memread  = 1'b0;
      memwrite = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset_stall", 128'(stall), 128'(0));
      checkOutput("reset_mem_read", 128'(mem_read), 128'(0));
      checkOutput("reset_mem_write", 128'(mem_write), 128'(0));
      checkOutput("reset_mem_addr", 128'(mem_addr), 128'(0));
      checkOutput("reset_rdata", 128'(rdata), 128'(0));
      reset = 1'b0;

      // Cold load miss, store hit, reload, dirty-victim miss.
      applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0);

      // Dirty line 0 again, then abort its writeback with reset.
      applyStimulus(1'b0, 1'b1, 32'h0000_0440, 32'h1234_5678);
      abortWriteback(32'h0000_0000);
      applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0);

      // Load and store together on a hit behaves as a store.
      applyStimulus(1'b1, 1'b1, 32'h0000_0460, 32'hCAFE_F00D);
      applyStimulus(1'b1, 1'b0, 32'h0000_0460, 32'h0);

      // Fill every line, then reread each one.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, (32'd5 << 10) | (32'(i) << 7) | (32'(i % 4) << 5), $urandom);
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, (32'd5 << 10) | (32'(i) << 7) | (32'(i % 4) << 5), 32'h0);
      end

      // Random traffic over a small tag pool to mix hits, clean and dirty misses.
      for (int i = 0; i < 150; i++) begin
         a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 7)
            | (32'($urandom_range(0, 3)) << 5);
         op = $urandom_range(0, 3);
         applyStimulus(op != 2, op >= 2, a, $urandom);
      end
      idleCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
